// File: rtl/sublime_wave_fetch_pkg.sv
// Shared definitions for the wavetable fetch path: FSM state encoding and default widths.
package sublime_wave_fetch_pkg;

    localparam int unsigned DEF_ADDR_W = 10;
    localparam int unsigned DEF_FRAC_W = 8;
    localparam int unsigned DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH0 = 2'd1,
        ST_FETCH1 = 2'd2,
        ST_CALC   = 2'd3
    } state_t;

endpackage

// File: rtl/sublime_lerp.sv
// Combinational linear interpolator: s0 + ((s1 - s0) * frac) >>> FRAC_W, floor rounding.
module sublime_lerp
    import sublime_wave_fetch_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned FRAC_W = DEF_FRAC_W
) (
    input  logic signed [DATA_W-1:0] s0,
    input  logic signed [DATA_W-1:0] s1,
    input  logic        [FRAC_W-1:0] frac,
    output logic signed [DATA_W-1:0] sample
);

    logic signed [DATA_W:0]          w_diff;
    logic signed [FRAC_W:0]          w_frac_s;
    logic signed [DATA_W+FRAC_W+1:0] w_prod;
    logic signed [DATA_W+FRAC_W+1:0] w_shift;
    logic signed [DATA_W:0]          w_sum;

    assign w_diff   = $signed({s1[DATA_W-1], s1}) - $signed({s0[DATA_W-1], s0});
    assign w_frac_s = $signed({1'b0, frac});
    assign w_prod   = w_diff * w_frac_s;
    assign w_shift  = w_prod >>> FRAC_W;
    // Result always lies between s0 and s1, so dropping the top bit cannot overflow.
    assign w_sum    = $signed({s0[DATA_W-1], s0}) + $signed(w_shift[DATA_W:0]);
    assign sample   = w_sum[DATA_W-1:0];

endmodule

// File: rtl/sublime_wave_fetch.sv
// Wavetable reader: latches the NCO phase on start, fetches two adjacent entries, interpolates.
module sublime_wave_fetch
    import sublime_wave_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned FRAC_W = DEF_FRAC_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [31:0]              wave_addr,
    output logic                     mem_req,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic                     mem_ack,
    input  logic signed [DATA_W-1:0] mem_data,
    output logic signed [DATA_W-1:0] sample,
    output logic                     sample_valid,
    output logic                     busy,
    output logic                     overrun
);

    state_t                    r_state, w_state_nxt;
    logic [ADDR_W-1:0]         r_idx, w_idx_nxt;
    logic [FRAC_W-1:0]         r_frac, w_frac_nxt;
    logic signed [DATA_W-1:0]  r_s0, w_s0_nxt;
    logic signed [DATA_W-1:0]  r_s1, w_s1_nxt;
    logic                      r_mem_req, w_mem_req_nxt;
    logic [ADDR_W-1:0]         r_mem_addr, w_mem_addr_nxt;
    logic signed [DATA_W-1:0]  r_sample, w_sample_nxt;
    logic                      r_sample_valid, w_sample_valid_nxt;
    logic                      r_overrun, w_overrun_nxt;

    logic [ADDR_W-1:0]         w_in_idx;
    logic [FRAC_W-1:0]         w_in_frac;
    logic signed [DATA_W-1:0]  w_lerp;

    assign w_in_idx  = wave_addr[31 -: ADDR_W];
    assign w_in_frac = wave_addr[31-ADDR_W -: FRAC_W];

    generate
        if (ADDR_W + FRAC_W < 32) begin : g_low_bits
            logic w_unused_low;
            assign w_unused_low = ^wave_addr[31-ADDR_W-FRAC_W:0];
        end
    endgenerate

    sublime_lerp #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_lerp (
        .s0     (r_s0),
        .s1     (r_s1),
        .frac   (r_frac),
        .sample (w_lerp)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_idx          <= '0;
            r_frac         <= '0;
            r_s0           <= '0;
            r_s1           <= '0;
            r_mem_req      <= 1'b0;
            r_mem_addr     <= '0;
            r_sample       <= '0;
            r_sample_valid <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_idx          <= w_idx_nxt;
            r_frac         <= w_frac_nxt;
            r_s0           <= w_s0_nxt;
            r_s1           <= w_s1_nxt;
            r_mem_req      <= w_mem_req_nxt;
            r_mem_addr     <= w_mem_addr_nxt;
            r_sample       <= w_sample_nxt;
            r_sample_valid <= w_sample_valid_nxt;
            r_overrun      <= w_overrun_nxt;
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_idx_nxt          = r_idx;
        w_frac_nxt         = r_frac;
        w_s0_nxt           = r_s0;
        w_s1_nxt           = r_s1;
        w_mem_req_nxt      = r_mem_req;
        w_mem_addr_nxt     = r_mem_addr;
        w_sample_nxt       = r_sample;
        w_sample_valid_nxt = 1'b0;
        // Any start outside IDLE is dropped; the in-flight operation continues untouched.
        w_overrun_nxt      = start && (r_state != ST_IDLE);

        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_idx_nxt      = w_in_idx;
                    w_frac_nxt     = w_in_frac;
                    w_mem_req_nxt  = 1'b1;
                    w_mem_addr_nxt = w_in_idx;
                    w_state_nxt    = ST_FETCH0;
                end
            end
            ST_FETCH0: begin
                if (mem_ack) begin
                    w_s0_nxt       = mem_data;
                    w_mem_addr_nxt = r_idx + ADDR_W'(1);
                    w_state_nxt    = ST_FETCH1;
                end
            end
            ST_FETCH1: begin
                if (mem_ack) begin
                    w_s1_nxt      = mem_data;
                    w_mem_req_nxt = 1'b0;
                    w_state_nxt   = ST_CALC;
                end
            end
            ST_CALC: begin
                w_sample_nxt       = w_lerp;
                w_sample_valid_nxt = 1'b1;
                w_state_nxt        = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign mem_req      = r_mem_req;
    assign mem_addr     = r_mem_addr;
    assign sample       = r_sample;
    assign sample_valid = r_sample_valid;
    assign overrun      = r_overrun;
    assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sublime_wave_fetch.sv
// Directed bench for sublime_wave_fetch with a wait-state-programmable memory responder.
`timescale 1ns/1ps
module tb_sublime_wave_fetch;

    localparam int ADDR_W = 10;
    localparam int FRAC_W = 8;
    localparam int DATA_W = 16;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     start = 1'b0;
    logic [31:0]              wave_addr = '0;
    logic                     mem_req;
    logic [ADDR_W-1:0]        mem_addr;
    logic                     mem_ack = 1'b0;
    logic signed [DATA_W-1:0] mem_data = '0;
    logic signed [DATA_W-1:0] sample;
    logic                     sample_valid;
    logic                     busy;
    logic                     overrun;

    sublime_wave_fetch #(
        .ADDR_W (ADDR_W),
        .FRAC_W (FRAC_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .wave_addr    (wave_addr),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_data     (mem_data),
        .sample       (sample),
        .sample_valid (sample_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    logic signed [DATA_W-1:0] tbl [0:(1<<ADDR_W)-1];

    int n_checks = 0;
    int n_errors = 0;

    // Written only by the main initial block.
    int wait_cfg = 0;
    bit spurious = 1'b0;

    // Written only by the monitor/responder process.
    int cyc = 0;
    int n_valid = 0;
    int v_cyc = 0;
    int n_ovr = 0;
    int o_cyc = 0;
    int n_log = 0;
    int log_addr [0:63];
    int n_unstable = 0;
    int wcnt = 0;
    int hold_addr = 0;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always begin
        @(posedge clk);
        cyc++;
        #1;
        if (sample_valid) begin
            n_valid++;
            v_cyc = cyc;
        end
        if (overrun) begin
            n_ovr++;
            o_cyc = cyc;
        end
        if (rst) begin
            mem_ack = 1'b0;
            wcnt    = 0;
        end else if (mem_req) begin
            if (wcnt == 0)
                hold_addr = int'(mem_addr);
            else if (int'(mem_addr) != hold_addr)
                n_unstable++;
            if (wcnt == wait_cfg) begin
                mem_ack  = 1'b1;
                mem_data = tbl[mem_addr];
                log_addr[n_log % 64] = int'(mem_addr);
                n_log++;
                wcnt = 0;
            end else begin
                mem_ack = 1'b0;
                wcnt++;
            end
        end else begin
            wcnt     = 0;
            mem_ack  = spurious;
            mem_data = spurious ? 16'sh7abc : '0;
        end
    end

    task automatic run_op(input string tag, input logic [31:0] addr, input int wcfg,
                          input int exp_s, input int exp_a0, input int exp_a1);
        int t0, b_valid, b_log, b_ovr, b_uns;
        bit done;
        wait_cfg = wcfg;
        @(negedge clk);
        b_valid = n_valid; b_log = n_log; b_ovr = n_ovr; b_uns = n_unstable;
        wave_addr = addr;
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 80 && !done; i++) begin
            @(negedge clk);
            if (n_valid > b_valid) done = 1'b1;
        end
        check({tag, "_timeout"}, 32'(done), 1);
        check({tag, "_latency"}, v_cyc - t0, 4 + 2 * wcfg);
        check({tag, "_sample"}, sample, exp_s);
        check({tag, "_nreads"}, n_log - b_log, 2);
        check({tag, "_addr0"}, log_addr[b_log % 64], exp_a0);
        check({tag, "_addr1"}, log_addr[(b_log + 1) % 64], exp_a1);
        repeat (4) @(negedge clk);
        check({tag, "_nvalid"}, n_valid - b_valid, 1);
        check({tag, "_noovr"}, n_ovr - b_ovr, 0);
        check({tag, "_stable"}, n_unstable - b_uns, 0);
        check({tag, "_hold"}, sample, exp_s);
        check({tag, "_idle"}, 32'(busy), 0);
        check({tag, "_reqlow"}, 32'(mem_req), 0);
    endtask

    initial begin : main
        int b_valid, b_ovr, t0;
        bit done;

        for (int i = 0; i < (1 << ADDR_W); i++) tbl[i] = '0;

        repeat (3) @(negedge clk);
        check("rst_req", 32'(mem_req), 0);
        check("rst_addr", 32'(mem_addr), 0);
        check("rst_sample", sample, 0);
        check("rst_valid", 32'(sample_valid), 0);
        check("rst_ovr", 32'(overrun), 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        tbl[64] = 16'sd1000; tbl[65] = 16'sd2000;
        run_op("frac0",  32'h1000_0000, 0, 1000, 64, 65);
        run_op("frac128", 32'h1020_0000, 0, 1500, 64, 65);
        run_op("frac32", 32'h1008_0000, 0, 1125, 64, 65);

        tbl[64] = 16'sd2000; tbl[65] = -16'sd2000;
        run_op("negslope", 32'h1010_0000, 0, 1000, 64, 65);

        tbl[64] = 16'sd0; tbl[65] = -16'sd3;
        run_op("floor", 32'h1020_0000, 0, -2, 64, 65);

        tbl[1023] = -16'sd5; tbl[0] = 16'sd7;
        run_op("wrap", 32'hFFC0_0000, 0, -5, 1023, 0);

        tbl[64] = 16'sd1000; tbl[65] = 16'sd2000;
        run_op("wait3", 32'h1020_0000, 3, 1500, 64, 65);

        // Spurious ack while idle must not start anything.
        @(negedge clk);
        b_valid = n_valid;
        spurious = 1'b1;
        repeat (4) @(negedge clk);
        check("spur_busy", 32'(busy), 0);
        check("spur_req", 32'(mem_req), 0);
        spurious = 1'b0;
        repeat (2) @(negedge clk);
        check("spur_nvalid", n_valid - b_valid, 0);

        // Overrun: second start two cycles after the first.
        wait_cfg = 0;
        @(negedge clk);
        b_valid = n_valid; b_ovr = n_ovr;
        wave_addr = 32'h1020_0000;
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        wave_addr = 32'hFFC0_0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("ovr_count", n_ovr - b_ovr, 1);
        check("ovr_cycle", o_cyc - t0, 3);
        check("ovr_nvalid", n_valid - b_valid, 1);
        check("ovr_latency", v_cyc - t0, 4);
        check("ovr_sample", sample, 1500);

        // Reset during the FETCH1 wait.
        wait_cfg = 4;
        @(negedge clk);
        b_valid = n_valid;
        t0 = n_log;
        wave_addr = 32'h1000_0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (n_log > t0) done = 1'b1;
        end
        check("rstmid_fetch0", 32'(done), 1);
        repeat (2) @(negedge clk);
        check("rstmid_pre_req", 32'(mem_req), 1);
        #2 rst = 1'b1;
        #1;
        check("rstmid_req", 32'(mem_req), 0);
        check("rstmid_busy", 32'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("rstmid_nvalid", n_valid - b_valid, 0);
        check("rstmid_sample", sample, 0);

        run_op("after_rst", 32'h1000_0000, 0, 1000, 64, 65);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
